vend_change_fsm: RTL

//  Parametrised coin-operated vending controller: accumulates nickel/dime/quarter credit,

---
 rtl/vend_pkg.sv | 26 ++
 rtl/coin_value_decode.sv | 20 ++
 rtl/vend_change_fsm.sv | 108 ++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the coin-operated vending controller:
// coin codes, coin values in cents and the controller state encoding.
package vend_pkg;

    // Coin codes presented on the 2-bit coin input
    localparam logic [1:0] COIN_NONE    = 2'b00;
    localparam logic [1:0] COIN_NICKEL  = 2'b01;
    localparam logic [1:0] COIN_DIME    = 2'b10;
    localparam logic [1:0] COIN_QUARTER = 2'b11;

    // Coin values in cents; one change pulse returns NICKEL_CENTS
    localparam int unsigned NICKEL_CENTS  = 5;
    localparam int unsigned DIME_CENTS    = 10;
    localparam int unsigned QUARTER_CENTS = 25;

    // Width needed to hold the largest single coin value
    localparam int unsigned COIN_VAL_W = 5;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2,
        ST_REFUND = 2'd3
    } state_e;

endpackage

// File: rtl/coin_value_decode.sv
// Combinational decode of a 2-bit coin code into its value in cents.
module coin_value_decode
    import vend_pkg::*;
(
    input  logic [1:0]            code_i,
    output logic [COIN_VAL_W-1:0] cents_o
);

    // Map each coin code to its cent value; no coin decodes to zero
    always_comb begin
        cents_o = '0;
        case (code_i)
            COIN_NICKEL:  cents_o = COIN_VAL_W'(NICKEL_CENTS);
            COIN_DIME:    cents_o = COIN_VAL_W'(DIME_CENTS);
            COIN_QUARTER: cents_o = COIN_VAL_W'(QUARTER_CENTS);
            default:      cents_o = '0;
        endcase
    end

endmodule

// File: rtl/vend_change_fsm.sv
// Coin-operated vending controller: accumulates nickel/dime/quarter credit,
// pulses vend once credit reaches PRICE, then pays back any overpayment one
// nickel per cycle. Cancel in ACCUM refunds held credit as nickels.
// Configuration macro VEND_CHANGE_EN: when defined, overpayment is returned
// through the CHANGE state; when undefined, VEND clears credit (overpayment
// forfeited) and CHANGE is never entered. Refund is always available.
// Parameter rule: PRICE multiple of 5, 5..255, and 2**CREDIT_W > PRICE+20.
module vend_change_fsm
    import vend_pkg::*;
#(
    parameter int unsigned PRICE    = 15,
    parameter int unsigned CREDIT_W = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic                ready,
    output logic                vend,
    output logic                change_nickel,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit
);

    localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] NICKEL_C = CREDIT_W'(NICKEL_CENTS);

    state_e                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic                  ready_q, vend_q, change_q, reject_q;
    logic                  ready_d, vend_d, change_d, reject_d;
    logic [COIN_VAL_W-1:0] coin_cents;
    logic [CREDIT_W-1:0]   credit_sum;

    coin_value_decode u_decode (
        .code_i  (coin),
        .cents_o (coin_cents)
    );

    assign credit_sum = credit_q + CREDIT_W'(coin_cents);

    // Next state, next credit and next registered output values
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        // A coin is taken only in ACCUM without cancel; anything else bounces
        reject_d = (coin != COIN_NONE) && !((state_q == ST_ACCUM) && !cancel);
        case (state_q)
            ST_ACCUM: begin
                if (cancel) begin
                    if (credit_q != '0) state_d = ST_REFUND;
                end else if (coin != COIN_NONE) begin
                    credit_d = credit_sum;
                    if (credit_sum >= PRICE_C) state_d = ST_VEND;
                end
            end
            ST_VEND: begin
`ifdef VEND_CHANGE_EN
                credit_d = credit_q - PRICE_C;
                state_d  = (credit_q == PRICE_C) ? ST_ACCUM : ST_CHANGE;
`else
                credit_d = '0;
                state_d  = ST_ACCUM;
`endif
            end
`ifdef VEND_CHANGE_EN
            ST_CHANGE,
`endif
            ST_REFUND: begin
                credit_d = credit_q - NICKEL_C;
                if (credit_q == NICKEL_C) state_d = ST_ACCUM;
            end
            default: begin
                state_d  = ST_ACCUM;
                credit_d = '0;
            end
        endcase
        ready_d  = (state_d == ST_ACCUM);
        vend_d   = (state_d == ST_VEND);
        change_d = (state_d == ST_CHANGE) || (state_d == ST_REFUND);
    end

    // State, credit and output registers; reset returns to idle ACCUM
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_ACCUM;
            credit_q <= '0;
            ready_q  <= 1'b1;
            vend_q   <= 1'b0;
            change_q <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            ready_q  <= ready_d;
            vend_q   <= vend_d;
            change_q <= change_d;
            reject_q <= reject_d;
        end
    end

    assign ready         = ready_q;
    assign vend          = vend_q;
    assign change_nickel = change_q;
    assign coin_reject   = reject_q;
    assign credit        = credit_q;

endmodule
